// File: rtl/state_event_log_if.sv
// rtl/state_event_log_if.sv - event input, FIFO readout and status bundle for state_event_log
interface state_event_log_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int TS_W   = 16
);
  logic                   in_valid;
  logic [DATA_W-1:0]      in_state;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_state;
  logic [TS_W-1:0]        out_ts;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   clear_ovf;

  modport master (
    output in_valid, in_state, out_ready, clear_ovf,
    input  out_valid, out_state, out_ts, count, overflow
  );

  modport slave (
    input  in_valid, in_state, out_ready, clear_ovf,
    output out_valid, out_state, out_ts, count, overflow
  );
endinterface

// File: rtl/state_event_log.sv
// rtl/state_event_log.sv - timestamped, de-duplicated settled-state FIFO with FWFT readout
// Define STATE_LOG_OVERWRITE_EN to overwrite the oldest entry on overflow instead of dropping.
module state_event_log #(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 8,
  parameter int TS_W     = 16,
  parameter int TICK_DIV = 10000
) (
  input  logic             clk,
  input  logic             reset,
  state_event_log_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0]  r_pre;
  logic [TS_W-1:0]   r_ts;
  logic [DATA_W-1:0] r_mem_state [DEPTH];
  logic [TS_W-1:0]   r_mem_ts    [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic [DATA_W-1:0] r_last_state;
  logic              r_last_vld;
  logic [DATA_W-1:0] r_hold_state;
  logic [TS_W-1:0]   r_hold_ts;

  logic w_valid, w_full, w_pop, w_cand, w_full_hit, w_write, w_rd_adv, w_inc, w_dec;

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = w_valid && bus.out_ready;
  assign w_cand     = bus.in_valid && !(r_last_vld && (bus.in_state == r_last_state));
  assign w_full_hit = w_cand && w_full && !w_pop;
`ifdef STATE_LOG_OVERWRITE_EN
  // Full without pop: the write lands on the oldest slot and the head steps past it.
  assign w_write  = w_cand;
  assign w_rd_adv = w_pop || w_full_hit;
`else
  assign w_write  = w_cand && !w_full_hit;
  assign w_rd_adv = w_pop;
`endif
  assign w_inc = w_write && !w_pop && !w_full;
  assign w_dec = w_pop && !w_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
      r_ts  <= '0;
    end else if (r_pre == PRE_W'(TICK_DIV - 1)) begin
      r_pre <= '0;
      r_ts  <= r_ts + TS_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_write && !reset) begin
      r_mem_state[r_wr_ptr] <= bus.in_state;
      r_mem_ts[r_wr_ptr]    <= r_ts;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_last_state <= '0;
      r_last_vld   <= 1'b0;
      r_hold_state <= '0;
      r_hold_ts    <= '0;
    end else begin
      if (w_write)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_inc)      r_count <= r_count + CNT_W'(1);
      else if (w_dec) r_count <= r_count - CNT_W'(1);
      if (w_full_hit)         r_ovf <= 1'b1;
      else if (bus.clear_ovf) r_ovf <= 1'b0;
      if (w_cand) begin
        r_last_state <= bus.in_state;
        r_last_vld   <= 1'b1;
      end
      // Remember the presented head so the outputs hold it once the FIFO drains.
      if (w_valid) begin
        r_hold_state <= r_mem_state[r_rd_ptr];
        r_hold_ts    <= r_mem_ts[r_rd_ptr];
      end
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_state = w_valid ? r_mem_state[r_rd_ptr] : r_hold_state;
  assign bus.out_ts    = w_valid ? r_mem_ts[r_rd_ptr] : r_hold_ts;
  assign bus.count     = r_count;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_state_event_log.sv
// tb/tb_state_event_log.sv - vector table, corner sequences and random model check of state_event_log
module tb_state_event_log;
  localparam int DEPTH = 8;
  localparam int TDIV  = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  state_event_log_if #(.DEPTH(DEPTH), .DATA_W(8), .TS_W(16)) bus ();

  state_event_log #(.DEPTH(DEPTH), .DATA_W(8), .TS_W(16), .TICK_DIV(TDIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] st;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] es;
    logic [3:0] ec;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic iv, logic [7:0] st, logic rdy, logic clr,
                              logic ev, logic [7:0] es, logic [3:0] ec, logic eo);
    vec_t v;
    v.iv = iv; v.st = st; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.es = es; v.ec = ec; v.eo = eo;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] st, input logic rdy, input logic clr);
    bus.in_valid  = iv;
    bus.in_state  = st;
    bus.out_ready = rdy;
    bus.clear_ovf = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of entries plus cycle count since reset for the timestamp.
  int         m_n;
  logic [7:0] m_qs[$];
  logic [15:0] m_qt[$];
  logic       m_lv;
  logic [7:0] m_ls;
  logic       m_ovf;
  logic [7:0] m_hs;
  logic [15:0] m_ht;

  function automatic void model_reset();
    m_n = 0; m_qs.delete(); m_qt.delete();
    m_lv = 1'b0; m_ls = '0; m_ovf = 1'b0; m_hs = '0; m_ht = '0;
  endfunction

  function automatic void model_step(logic iv, logic [7:0] st, logic rdy, logic clr);
    logic [15:0] cur_ts;
    logic        pop, cand, set_ovf;
    cur_ts  = 16'((m_n / TDIV) % 65536);
    pop     = (m_qs.size() != 0) && rdy;
    cand    = iv && !(m_lv && st == m_ls);
    set_ovf = 1'b0;
    if (cand) begin m_lv = 1'b1; m_ls = st; end
    if (pop) begin void'(m_qs.pop_front()); void'(m_qt.pop_front()); end
    if (cand) begin
      if (m_qs.size() < DEPTH) begin
        m_qs.push_back(st); m_qt.push_back(cur_ts);
      end else begin
        set_ovf = 1'b1;
`ifdef STATE_LOG_OVERWRITE_EN
        void'(m_qs.pop_front()); void'(m_qt.pop_front());
        m_qs.push_back(st); m_qt.push_back(cur_ts);
`endif
      end
    end
    if (set_ovf)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_n++;
  endfunction

  initial begin
    logic [7:0] h1;
    logic [7:0] drain[$];
    int rdy_pct;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset state
    repeat (2) tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    chk("rst_state", 32'(bus.out_state), 32'd0);
    chk("rst_ts",    32'(bus.out_ts), 32'd0);

    // First event after release at cycle 9 carries ts=2, visible one cycle later
    reset = 1'b0;
    repeat (9) tick();
    chk("lat_valid_before", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_state", 32'(bus.out_state), 32'h5A);
    chk("lat_ts",    32'(bus.out_ts), 32'd2);
    chk("lat_count", 32'(bus.count), 32'd1);

    // Vector table: dedup, drain/hold, fill, overflow, full push+pop, clear priority
`ifdef STATE_LOG_OVERWRITE_EN
    h1 = 8'h02;
`else
    h1 = 8'h01;
`endif
    add(1, 8'h5A, 0, 0, 1, 8'h5A, 1, 0);
    add(1, 8'h5A, 0, 0, 1, 8'h5A, 1, 0);
    add(1, 8'h3C, 0, 0, 1, 8'h5A, 2, 0);
    add(0, 8'h00, 1, 0, 1, 8'h3C, 1, 0);
    add(0, 8'h00, 1, 0, 0, 8'h3C, 0, 0);
    for (int i = 1; i <= 8; i++) add(1, 8'(i), 0, 0, 1, 8'h01, 4'(i), 0);
    add(1, 8'h09, 0, 0, 1, h1, 8, 1);
    add(1, 8'h0A, 1, 0, 1, h1 + 8'd1, 8, 1);
    for (int i = 0; i < 7; i++) drain.push_back(h1 + 8'd1 + 8'(i));
    drain.push_back(8'h0A);
    for (int i = 1; i < 8; i++) add(0, 8'h00, 1, 0, 1, drain[i], 4'(8 - i), 1);
    add(0, 8'h00, 1, 0, 0, 8'h0A, 0, 1);
    add(0, 8'h00, 0, 1, 0, 8'h0A, 0, 0);
    for (int i = 1; i <= 8; i++) add(1, 8'h10 + 8'(i), 0, 0, 1, 8'h11, 4'(i), 0);
    add(1, 8'h19, 0, 1, 1, h1 + 8'h10, 8, 1);
    add(0, 8'h00, 0, 1, 1, h1 + 8'h10, 8, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].st, vecs[i].rdy, vecs[i].clr);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_state", i), 32'(bus.out_state), 32'(vecs[i].es));
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].ec));
      chk($sformatf("vec%0d_ovf", i),   32'(bus.overflow), 32'(vecs[i].eo));
    end

    // Randomized run against the queue model, with occasional mid-run resets
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    rdy_pct = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic iv, rdy, clr, rst;
      logic [7:0] st;
      logic ev;
      ev = (m_qs.size() != 0);
      chk("rnd_valid", 32'(bus.out_valid), 32'(ev));
      chk("rnd_state", 32'(bus.out_state), 32'(ev ? m_qs[0] : m_hs));
      chk("rnd_ts",    32'(bus.out_ts),    32'(ev ? m_qt[0] : m_ht));
      chk("rnd_count", 32'(bus.count),     32'(m_qs.size()));
      chk("rnd_ovf",   32'(bus.overflow),  32'(m_ovf));
      if (ev) begin m_hs = m_qs[0]; m_ht = m_qt[0]; end
      if (cyc % 200 == 0) rdy_pct = (cyc / 200) % 3 == 0 ? 10 : ((cyc / 200) % 3 == 1 ? 50 : 90);
      iv  = ($urandom_range(0, 2) == 0);
      st  = 8'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 99) < rdy_pct);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      drive(iv, st, rdy, clr);
      reset = rst;
      if (rst) model_reset();
      else     model_step(iv, st, rdy, clr);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
